rom_fetch_arbiter: RTL and testbench
====================================

# rom_fetch_arbiter

Sequences the processor's 16-bit program/constant ROM and shares its single read port between two requesters: instruction fetch (IF) and data/constant read (DR). It owns the ROM's `addr`/`CS`/`OE` pins, waits out the ROM's fixed read latency, and returns the word to the winning requester with a one-cycle valid strobe. It sits between the fetch/decode logic and the ROM instance, and allows one outstanding read at a time.

## Interface
- `AW`, 8: ROM address width.
- `DW`, 16: ROM data width.
- `ROM_LAT`, 2: cycles from the first cycle `rom_addr`/`rom_oe` are driven to the edge where `rom_data` is sampled. Legal range ≥1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `if_req`  in  1  IF read request; held with `if_addr` until `if_ack`.
- `if_addr`  in  AW  IF word address.
- `if_ack`  out  1  one-cycle pulse: IF request accepted.
- `if_valid`  out  1  one-cycle pulse: `if_data` holds the new word.
- `if_data`  out  DW  last word returned to IF.
- `dr_req`, `dr_addr`, `dr_ack`, `dr_valid`, `dr_data`: same as the IF ports, for DR.
- `rom_addr`  out  AW  ROM address.
- `rom_cs`  out  1  ROM chip select.
- `rom_oe`  out  1  ROM output enable.
- `rom_data`  in  DW  ROM read data. Reads 16'hFFFF while OE is low.
- `busy`  out  1  high while in state BUSY.

## Operation
- FSM states: IDLE, BUSY.
- **IDLE**
  - `rom_cs` = `rom_oe` = 0; `rom_addr` holds its last value.
  - On an edge with any request high: arbitrate, latch the winner's address into `rom_addr`, latch the winner's id, load the counter with `ROM_LAT-1`, pulse the winner's ack in the next cycle, and go to BUSY.
- **BUSY**
  - `rom_cs` = `rom_oe` = 1.
  - Counter decrements each cycle.
  - On the edge where the counter is 0: capture `rom_data` into the winner's data register, pulse the winner's valid in the next cycle, and return to IDLE.
- The loser's request is ignored until the FSM is back in IDLE. The loser must keep its request and address stable.
- `if_data`/`dr_data` hold their value until that requester's next valid.
- Requests arriving while BUSY are not acknowledged and are not lost. They are evaluated in the next IDLE cycle.
- Dropping a request after its ack has no effect; the read still completes and valid still pulses.
- Default arbitration is fixed priority: IF beats DR on a simultaneous request.
- Addresses pass through unmodified; there is no arithmetic and no wrap logic.
- **Reset, including mid-read:**
  - State → IDLE; counter → 0.
  - `rom_addr` = 0, `rom_cs` = 0, `rom_oe` = 0.
  - All ack and valid outputs = 0; `busy` = 0.
  - `if_data` = `dr_data` = 0.
  - Round-robin pointer favours IF.
  - An aborted read produces no valid.

## Timing
- Request sampled high at the end of cycle 0:
  - Cycle 1: ack = 1, `busy` = 1, `rom_addr`/`rom_cs`/`rom_oe` driven.
  - Cycles 1..`ROM_LAT`: ROM pins are stable.
  - End of cycle `ROM_LAT`: `rom_data` is sampled.
  - Cycle `ROM_LAT+1`: valid = 1 with data; FSM is in IDLE.
- Request-to-valid latency: `ROM_LAT+1` cycles.
- Back-to-back throughput: one read per `ROM_LAT+1` cycles. The next ack can appear in cycle `ROM_LAT+2`.
- Ack and valid are registered and last exactly one cycle.
- At most one ack and at most one valid are high in any cycle.

## Configuration
- `ROM_ARB_ROUND_ROBIN_EN`
  - Defined: on a simultaneous IF+DR request, the requester not granted last wins. A 1-bit pointer updates on every grant and resets to favour IF.
  - Undefined: fixed priority, IF always wins; no pointer state exists.
  - Single-requester behaviour is identical in both builds.

## Test plan
Bench ROM model: returns {8'hC0, addr} `ROM_LAT` cycles after OE; `ROM_LAT` = 2.

- **Single IF read.** `if_req`=1, `if_addr`=8'h05 for one cycle → `if_ack` in cycle 1; `rom_addr`=8'h05 with `rom_oe`=1 in cycles 1–2; `if_valid`=1 with `if_data`=16'hC005 in cycle 3; `dr_*` stays 0.
- **Simultaneous requests, fixed priority.** `if_addr`=8'h10 and `dr_addr`=8'h20 held → IF acked first and returns 16'hC010; DR acked in cycle 4 and returns 16'hC020 in cycle 6.
- **Round robin** (`ROM_ARB_ROUND_ROBIN_EN` defined). Both requests held continuously → grants alternate IF, DR, IF, DR; data values are correct for each.
- **Back-to-back IF.** `if_req` held with `if_addr` stepping 8'hFE, 8'hFF, 8'h00 → acks exactly 3 cycles apart; data 16'hC0FE, 16'hC0FF, 16'hC000.
- **Reset mid-read.** `rst` asserted in cycle 2 of a DR read → next cycle shows IDLE, `rom_oe`=0, `busy`=0, `dr_data`=0; no `dr_valid` ever appears for that read.
- **Late drop.** `dr_req` dropped the cycle after `dr_ack` → `dr_valid` still pulses with the correct word.

Source files
------------

// File: rtl/rom_fetch_arbiter.sv
// rom_fetch_arbiter: sequences a single-port ROM for two requesters,
// instruction fetch (IF) and data/constant read (DR). It allows one
// outstanding read at a time. Each read waits ROM_LAT cycles and then
// returns the word with a one-cycle valid strobe.
// Optional build macro ROM_ARB_ROUND_ROBIN_EN: when it is defined, a
// simultaneous IF+DR request goes to whichever side was not granted last.
// When it is undefined, IF always wins.
module rom_fetch_arbiter #(
  parameter int unsigned AW      = 8,
  parameter int unsigned DW      = 16,
  parameter int unsigned ROM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic          if_valid,
  output logic [DW-1:0] if_data,
  input  logic          dr_req,
  input  logic [AW-1:0] dr_addr,
  output logic          dr_ack,
  output logic          dr_valid,
  output logic [DW-1:0] dr_data,
  output logic [AW-1:0] rom_addr,
  output logic          rom_cs,
  output logic          rom_oe,
  input  logic [DW-1:0] rom_data,
  output logic          busy
);

  localparam int unsigned CW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [AW-1:0] addr_n;
  logic          owner_dr, owner_dr_n;
  logic          if_ack_n, dr_ack_n;
  logic          if_valid_n, dr_valid_n;
  logic [DW-1:0] if_data_n, dr_data_n;
  logic          pick_dr;

`ifdef ROM_ARB_ROUND_ROBIN_EN
  logic last_dr;

  // Grant selection: on a tie, the side that was not granted last wins.
  always_comb begin
    pick_dr = dr_req && (!if_req || !last_dr);
  end

  // Remember the last grant. Reset points at DR so that IF is favoured.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_dr <= 1'b1;
    end else if (state == IDLE && (if_req || dr_req)) begin
      last_dr <= pick_dr;
    end
  end
`else
  // Grant selection: fixed priority, IF wins a tie.
  always_comb begin
    pick_dr = dr_req && !if_req;
  end
`endif

  // The ROM pins are active for the whole BUSY window.
  assign rom_cs = (state == BUSY);
  assign rom_oe = (state == BUSY);
  assign busy   = (state == BUSY);

  // Next-state logic, plus the registered ack/valid/data values.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    addr_n     = rom_addr;
    owner_dr_n = owner_dr;
    if_ack_n   = 1'b0;
    dr_ack_n   = 1'b0;
    if_valid_n = 1'b0;
    dr_valid_n = 1'b0;
    if_data_n  = if_data;
    dr_data_n  = dr_data;
    case (state)
      IDLE: begin
        if (if_req || dr_req) begin
          state_n    = BUSY;
          cnt_n      = CW'(ROM_LAT - 1);
          addr_n     = pick_dr ? dr_addr : if_addr;
          owner_dr_n = pick_dr;
          if_ack_n   = !pick_dr;
          dr_ack_n   = pick_dr;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          state_n = IDLE;
          if (owner_dr) begin
            dr_data_n  = rom_data;
            dr_valid_n = 1'b1;
          end else begin
            if_data_n  = rom_data;
            if_valid_n = 1'b1;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers. Reset abandons any read that is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rom_addr <= '0;
      owner_dr <= 1'b0;
      if_ack   <= 1'b0;
      dr_ack   <= 1'b0;
      if_valid <= 1'b0;
      dr_valid <= 1'b0;
      if_data  <= '0;
      dr_data  <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      rom_addr <= addr_n;
      owner_dr <= owner_dr_n;
      if_ack   <= if_ack_n;
      dr_ack   <= dr_ack_n;
      if_valid <= if_valid_n;
      dr_valid <= dr_valid_n;
      if_data  <= if_data_n;
      dr_data  <= dr_data_n;
    end
  end

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Testbench for rom_fetch_arbiter. It compares the DUT cycle by cycle
// against a transaction-level model that tracks grant times.
module tb_rom_fetch_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dr_req;
  logic [7:0]  if_addr, dr_addr;
  logic        if_ack, dr_ack, if_valid, dr_valid;
  logic [15:0] if_data, dr_data;
  logic [7:0]  rom_addr;
  logic        rom_cs, rom_oe, busy;
  logic [15:0] rom_data;

  rom_fetch_arbiter #(.AW(8), .DW(16), .ROM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_valid(if_valid), .if_data(if_data),
    .dr_req(dr_req), .dr_addr(dr_addr), .dr_ack(dr_ack), .dr_valid(dr_valid), .dr_data(dr_data),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_oe(rom_oe), .rom_data(rom_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // ROM model: the word is valid only in the LAT-th cycle of OE being
  // high. Earlier cycles of OE return junk, and OE low returns FFFF.
  int oe_run = 0;
  always @(posedge clk) oe_run <= rom_oe ? oe_run + 1 : 0;
  always_comb begin
    if (!rom_oe)              rom_data = 16'hFFFF;
    else if (oe_run == LAT-1) rom_data = {8'hC0, rom_addr};
    else                      rom_data = 16'hBAD0;
  end

  // Reference model. It records when each read was granted and derives
  // every expected output from that cycle number.
  int          cyc = 0;
  int          g_cyc = -100;
  int          free_cyc = 0;
  bit          g_dr = 1'b0;
  logic [7:0]  g_addr = '0;
  logic [15:0] m_if_data = '0, m_dr_data = '0;
  logic [7:0]  m_rom_addr = '0;
  bit          m_last_dr = 1'b1;
  int          n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit ack_if_now();
    return (cyc == g_cyc + 1) && !g_dr;
  endfunction

  function automatic bit ack_dr_now();
    return (cyc == g_cyc + 1) && g_dr;
  endfunction

  // Advance one clock. The model first consumes the inputs sampled at this
  // edge. Then, #1 after the edge, every DUT output is compared.
  task automatic tick();
    bit   want_dr;
    logic e_busy, e_if_ack, e_dr_ack, e_if_val, e_dr_val;
    if (rst) begin
      g_cyc      = -100;
      free_cyc   = cyc + 1;
      m_if_data  = '0;
      m_dr_data  = '0;
      m_rom_addr = '0;
      m_last_dr  = 1'b1;
    end else if (cyc >= free_cyc && (if_req || dr_req)) begin
`ifdef ROM_ARB_ROUND_ROBIN_EN
      want_dr = dr_req && (!if_req || !m_last_dr);
`else
      want_dr = dr_req && !if_req;
`endif
      g_cyc     = cyc;
      g_dr      = want_dr;
      g_addr    = want_dr ? dr_addr : if_addr;
      m_last_dr = want_dr;
      free_cyc  = cyc + LAT + 1;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (cyc == g_cyc + 1) m_rom_addr = g_addr;
    e_if_val = (cyc == g_cyc + LAT + 1) && !g_dr;
    e_dr_val = (cyc == g_cyc + LAT + 1) && g_dr;
    if (e_if_val) m_if_data = {8'hC0, g_addr};
    if (e_dr_val) m_dr_data = {8'hC0, g_addr};
    e_busy   = (cyc > g_cyc) && (cyc <= g_cyc + LAT);
    e_if_ack = ack_if_now();
    e_dr_ack = ack_dr_now();
    check("if_ack",   32'(if_ack),   32'(e_if_ack));
    check("dr_ack",   32'(dr_ack),   32'(e_dr_ack));
    check("if_valid", 32'(if_valid), 32'(e_if_val));
    check("dr_valid", 32'(dr_valid), 32'(e_dr_val));
    check("busy",     32'(busy),     32'(e_busy));
    check("rom_oe",   32'(rom_oe),   32'(e_busy));
    check("rom_cs",   32'(rom_cs),   32'(e_busy));
    check("rom_addr", 32'(rom_addr), 32'(m_rom_addr));
    check("if_data",  32'(if_data),  32'(m_if_data));
    check("dr_data",  32'(dr_data),  32'(m_dr_data));
  endtask

  initial begin
    int n_b2b;
    rst = 1'b1; if_req = 1'b0; dr_req = 1'b0; if_addr = '0; dr_addr = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Single IF read
    if_req = 1'b1; if_addr = 8'h05;
    tick();
    if_req = 1'b0;
    repeat (4) tick();

    // Simultaneous requests, each held until its own ack
    if_req = 1'b1; dr_req = 1'b1; if_addr = 8'h10; dr_addr = 8'h20;
    repeat (10) begin
      tick();
      if (ack_if_now()) if_req = 1'b0;
      if (ack_dr_now()) dr_req = 1'b0;
    end

    // Both held continuously: exercises the arbitration order
    if_req = 1'b1; dr_req = 1'b1; if_addr = 8'h41; dr_addr = 8'h82;
    repeat (13) tick();
    if_req = 1'b0; dr_req = 1'b0;
    repeat (4) tick();

    // Back-to-back IF, with the address stepping across the wrap point
    n_b2b = 0;
    if_req = 1'b1; if_addr = 8'hFE;
    repeat (12) begin
      tick();
      if (ack_if_now()) begin
        n_b2b++;
        if (n_b2b == 1)      if_addr = 8'hFF;
        else if (n_b2b == 2) if_addr = 8'h00;
        else                 if_req = 1'b0;
      end
    end
    check("b2b_ack_count", 32'(n_b2b), 32'd3);

    // Reset during the second cycle of a DR read
    dr_req = 1'b1; dr_addr = 8'h33;
    tick();
    dr_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (4) tick();

    // Late drop: DR request released the cycle after its ack
    dr_req = 1'b1; dr_addr = 8'h7A;
    tick();
    tick();
    dr_req = 1'b0;
    repeat (4) tick();

    // Random traffic, with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if (ack_if_now()) begin
        if_req = 1'($urandom_range(0, 1)); if_addr = 8'($urandom);
      end else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = 8'($urandom);
      end
      if (ack_dr_now()) begin
        dr_req = 1'($urandom_range(0, 1)); dr_addr = 8'($urandom);
      end else if (!dr_req && $urandom_range(0, 2) == 0) begin
        dr_req = 1'b1; dr_addr = 8'($urandom);
      end
      rst = ($urandom_range(0, 79) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
